// File: rtl/comparator_seq_pkg.sv
// comparator_seq_pkg: shared types and constants for the nibble-serial comparator.
// Provides the FSM state enum, the nibble width and the nibble-count helper.
package comparator_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } cmp_state_t;

    localparam int NIBBLE_W = 4;

    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/comparator_seq_ctrl_if.sv
// comparator_seq_ctrl_if: operand (valid/ready) and result (valid/ready) bundle.
// slave = comparator side; master = producer/consumer side.
interface comparator_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             eq;
    logic             gt;
    logic             lt;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, eq, gt, lt
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, eq, gt, lt
    );
endinterface

// File: rtl/comparator_4bit.sv
// comparator_4bit: combinational 4-bit unsigned magnitude comparator slice.
// Ports: i_a, i_b (4b operands); o_eq, o_gt, o_lt (one-hot result).
module comparator_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic       o_eq,
    output logic       o_gt,
    output logic       o_lt
);
    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a > i_b);
    assign o_lt = (i_a < i_b);
endmodule

// File: rtl/comparator_seq_ctrl.sv
// comparator_seq_ctrl: compares two WIDTH-bit operands one nibble per cycle, MSB first.
// Ports: clk, rst (sync, active-high), bus (slave: in_valid/in_ready/a/b, out_valid/out_ready/eq/gt/lt).
// Optional macro COMPARATOR_SEQ_EARLY_EXIT_EN: finish on the first unequal nibble.
module comparator_seq_ctrl
    import comparator_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    comparator_seq_ctrl_if.slave bus
);
    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
            $error("comparator_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    cmp_state_t          r_state;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [IDX_W-1:0]    r_idx;
    logic                r_decided;
    logic                r_gt;
    logic                r_lt;
    logic                r_eq_o;
    logic                r_gt_o;
    logic                r_lt_o;
    logic                r_in_ready;
    logic                r_out_valid;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic                w_s_eq;
    logic                w_s_gt;
    logic                w_s_lt;
    logic                w_accept;
    logic                w_dec_now;
    logic                w_last;
    logic                w_fin_eq;
    logic                w_fin_gt;
    logic                w_fin_lt;

    assign w_a_nib = r_a[int'(r_idx) * NIBBLE_W +: NIBBLE_W];
    assign w_b_nib = r_b[int'(r_idx) * NIBBLE_W +: NIBBLE_W];

    comparator_4bit u_slice (
        .i_a  (w_a_nib),
        .i_b  (w_b_nib),
        .o_eq (w_s_eq),
        .o_gt (w_s_gt),
        .o_lt (w_s_lt)
    );

    assign w_accept  = (r_state == ST_IDLE) && r_in_ready && bus.in_valid;
    assign w_dec_now = !w_s_eq && !r_decided;

`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    assign w_last = (r_idx == '0) || w_dec_now;
`else
    assign w_last = (r_idx == '0);
`endif

    // The first unequal nibble owns the verdict; lower nibbles only
    // matter when every higher nibble matched.
    assign w_fin_eq = !r_decided && w_s_eq;
    assign w_fin_gt = r_decided ? r_gt : w_s_gt;
    assign w_fin_lt = r_decided ? r_lt : w_s_lt;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= bus.a;
            r_b <= bus.b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_decided   <= 1'b0;
            r_gt        <= 1'b0;
            r_lt        <= 1'b0;
            r_eq_o      <= 1'b0;
            r_gt_o      <= 1'b0;
            r_lt_o      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_idx      <= IDX_LAST;
                        r_decided  <= 1'b0;
                        r_gt       <= 1'b0;
                        r_lt       <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_dec_now) begin
                        r_decided <= 1'b1;
                        r_gt      <= w_s_gt;
                        r_lt      <= w_s_lt;
                    end
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_eq_o      <= w_fin_eq;
                        r_gt_o      <= w_fin_gt;
                        r_lt_o      <= w_fin_lt;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.eq        = r_eq_o;
    assign bus.gt        = r_gt_o;
    assign bus.lt        = r_lt_o;

endmodule
